// File: rtl/count_arbiter.sv
// count_arbiter: round-robin owner of a shared counter unit.
// Each job runs CLEAR -> START -> WAIT -> RELEASE, and WAIT is bounded by a watchdog.
module count_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic            busy,
   output logic            ctr_clr,
   output logic            ctr_go,
   input  logic            ctr_done,
   output logic [NREQ-1:0] ack,
   output logic            timeout
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, RELEASE} state_e;
   state_e          state_q;
   logic [NREQ-1:0] grant_q, ack_q;
   logic            busy_q, clr_q, go_q, to_q, hit_d;
   logic [7:0]      wd_q;
   logic [IW-1:0]   last_q, own_q, sel_d;
   // first requester after the previous owner, wrapping modulo NREQ
   always_comb begin
      sel_d = last_q;
      hit_d = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!hit_d && req[IW'((int'(last_q) + i) % NREQ)]) begin
            sel_d = IW'((int'(last_q) + i) % NREQ);
            hit_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         clr_q   <= 1'b0;
         go_q    <= 1'b0;
         to_q    <= 1'b0;
         wd_q    <= '0;
         last_q  <= IW'(NREQ - 1);
         own_q   <= '0;
      end else begin
         clr_q <= 1'b0;
         go_q  <= 1'b0;
         ack_q <= '0;
         to_q  <= 1'b0;
         case (state_q)
            IDLE: if (hit_d) begin
               state_q <= CLEAR;
               grant_q <= NREQ'(1) << sel_d;
               own_q   <= sel_d;
               busy_q  <= 1'b1;
               clr_q   <= 1'b1;
            end
            CLEAR: begin
               state_q <= START;
               go_q    <= 1'b1;
            end
            START: begin
               state_q <= WAIT;
               wd_q    <= '0;
            end
            WAIT: begin
               // completion wins over a simultaneous watchdog expiry
               if (ctr_done || wd_q == 8'(TIMEOUT - 1)) begin
                  state_q <= RELEASE;
                  clr_q   <= 1'b1;
                  ack_q   <= ctr_done ? grant_q : '0;
                  to_q    <= !ctr_done;
               end else begin
                  wd_q <= wd_q + 8'd1;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               last_q  <= own_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign ctr_clr = clr_q;
   assign ctr_go  = go_q;
   assign ack     = ack_q;
   assign timeout = to_q;
endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: job-level reference model of count_arbiter checked cycle by cycle.
module tb_count_arbiter;
   localparam int N = 4, TO = 32;
   logic clk = 1'b0, rst_n = 1'b1, ctr_done = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant, ack;
   logic busy, ctr_clr, ctr_go, timeout;
   logic [11:0] obs;
   int checks = 0, errors = 0, last = N - 1;
   count_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .busy(busy),
      .ctr_clr(ctr_clr), .ctr_go(ctr_go), .ctr_done(ctr_done),
      .ack(ack), .timeout(timeout)
   );
   assign obs = {grant, busy, ctr_clr, ctr_go, ack, timeout};
   always #5 clk = ~clk;
   function automatic int pick(input logic [N-1:0] r, input int l);
      for (int i = 1; i <= N; i++) if (r[(l + i) % N]) return (l + i) % N;
      return -1;
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // one full job from IDLE; d = WAIT cycle in which ctr_done shows (d > TO: never)
   task automatic do_job(input logic [N-1:0] r, input int d, input bit drop, input bit junk, input string name);
      int o;
      logic [N-1:0] g;
      logic [11:0] e;
      req = r;
      o = pick(r, last);
      g = 4'b0001 << o;
      ctr_done = junk;
      step();
      e = {g, 3'b110, 4'b0000, 1'b0};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s_clear obs=%b exp=%b", name, obs, e); end
      step();
      ctr_done = 1'b0;
      e = {g, 3'b101, 4'b0000, 1'b0};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s_start obs=%b exp=%b", name, obs, e); end
      for (int w = 1; w <= ((d < TO) ? d : TO); w++) begin
         step();
         e = {g, 3'b100, 4'b0000, 1'b0};
         checks++;
         if (obs !== e) begin errors++; $display("FAIL %s_wait%0d obs=%b exp=%b", name, w, obs, e); end
         ctr_done = (w >= d);
         if (drop && w == 2) req[o] = 1'b0;
      end
      step();
      e = {g, 3'b110, (d <= TO) ? g : 4'b0000, d > TO};
      checks++;
      if (obs !== e) begin errors++; $display("FAIL %s_release obs=%b exp=%b", name, obs, e); end
      ctr_done = 1'b0;
      step();
      checks++;
      if (obs !== 12'b0) begin errors++; $display("FAIL %s_idle obs=%b exp=%b", name, obs, 12'b0); end
      last = o;
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      req = 4'b1111;
      ctr_done = 1'b1;
      repeat (3) begin
         step();
         checks++;
         if (obs !== 12'b0) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 12'b0); end
      end
      req = '0;
      ctr_done = 1'b0;
      rst_n = 1'b1;
      step();
      checks++;
      if (obs !== 12'b0) begin errors++; $display("FAIL reset_idle obs=%b exp=%b", obs, 12'b0); end
      last = N - 1;
   endtask
   task automatic test_single();
      do_job(4'b0001, 17, 0, 0, "single");
   endtask
   task automatic test_round_robin();
      for (int k = 0; k < 5; k++) do_job(4'b1111, 3, 0, 0, "rr");
   endtask
   task automatic test_timeout();
      do_job(4'b0100, 1000, 0, 0, "timeout");
      do_job(4'b0001, 5, 0, 0, "after_timeout");
   endtask
   task automatic test_tie();
      do_job(4'b1000, TO, 0, 0, "tie");
      do_job(4'b0010, TO - 1, 0, 0, "near_tie");
   endtask
   task automatic test_midreset();
      req = 4'b0010;
      repeat (4) step();
      checks++;
      if (grant !== 4'b0010) begin errors++; $display("FAIL midreset_owner grant=%b exp=%b", grant, 4'b0010); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 12'b0) begin errors++; $display("FAIL midreset_abort obs=%b exp=%b", obs, 12'b0); end
      step();
      req = 4'b0011;
      step();
      rst_n = 1'b1;
      last = N - 1;
      #1;
      checks++;
      if (obs !== 12'b0) begin errors++; $display("FAIL midreset_release obs=%b exp=%b", obs, 12'b0); end
      do_job(4'b0011, 5, 0, 0, "midreset_job");
      req = '0;
      step();
   endtask
   task automatic test_drop();
      do_job(4'b0100, 6, 1, 0, "drop");
      req = '0;
      repeat (2) begin
         step();
         checks++;
         if (obs !== 12'b0) begin errors++; $display("FAIL drop_regrant obs=%b exp=%b", obs, 12'b0); end
      end
   endtask
   task automatic test_random();
      for (int k = 0; k < 25; k++) begin
         do_job(4'($urandom_range(1, 15)), $urandom_range(1, 40), $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, "rand");
         if ($urandom_range(0, 2) == 0) begin
            req = '0;
            repeat ($urandom_range(1, 3)) begin
               step();
               checks++;
               if (obs !== 12'b0) begin errors++; $display("FAIL rand_gap obs=%b exp=%b", obs, 12'b0); end
            end
         end
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_tie();
      test_midreset();
      test_drop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "bench time limit");
   end
endmodule
